imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised, synchronous instruction memory for the MIPS core.
- Successor to the fixed, combinational instruction ROM: program is boot-loaded at run time through a streaming load port instead of hard-coded case entries.
- Fetch has registered 1-cycle latency with stall support, plus range/alignment error reporting.
- Sits between the loader (UART/testbench) and the IF stage.

Parameters:
- DEPTH, 256, number of instruction words (power of two, 4..4096); IDX_W = log2(DEPTH) derived internally.
- DATA_W, 32, instruction word width.
- NOP_WORD, 32'h00000000, word returned on any error or unloaded fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- load_start  in  1  pulse: begin new program load, write pointer cleared.
- load_valid  in  1  load_data is valid this cycle.
- load_last  in  1  qualifies final word of load (with load_valid).
- load_data  in  DATA_W  instruction word to store.
- load_ready  out  1  memory accepts a load word this cycle.
- load_done  out  1  program loaded; fetches served.
- prog_len  out  IDX_W+1  number of words loaded.
- fetch_req  in  1  IF stage requests instruction.
- fetch_addr  in  32  byte address (PC).
- fetch_stall  in  1  downstream stalled; hold output.
- fetch_valid  out  1  fetch_data/fetch_err valid.
- fetch_data  out  DATA_W  instruction word.
- fetch_err  out  1  misaligned, out of range, or not loaded.

Behaviour:
- Reset (async, rst_n=0): state EMPTY, wptr=0, prog_len=0, load_ready=0, load_done=0, fetch_valid=0, fetch_data=NOP_WORD, fetch_err=0. Memory array not reset.
- FSM states:
  - EMPTY: load_ready=0, load_done=0; load_start -> LOAD.
  - LOAD: load_ready=1, load_done=0.
  - READY: load_ready=0, load_done=1; load_start -> LOAD (reload).
- load_start in any state -> LOAD next cycle, wptr=0, prog_len=0.
- load_start has priority over a simultaneous load_valid; that word is dropped.
- LOAD write: load_valid & load_ready -> mem[wptr]=load_data, wptr++, prog_len=wptr+1.
- LOAD exit -> READY when either:
  - load_last accompanies the accepted word, or
  - the word written is at wptr=DEPTH-1 (memory full).
- Further load_valid in READY/EMPTY is ignored.
- Fetch pipeline, 1-cycle latency:
  - Capture when fetch_req & !fetch_stall.
  - Next cycle: fetch_valid=1, with fetch_data/fetch_err per the error rules.
  - No capture -> fetch_valid=0 next cycle (unless stalled).
- Stall: while fetch_stall=1, fetch_valid/fetch_data/fetch_err hold their values and fetch_req is ignored; capture resumes the cycle stall drops.
- Word index = fetch_addr[IDX_W+1:2].
- Error rules, evaluated at capture; any true -> fetch_data=NOP_WORD, fetch_err=1:
  - fetch_addr[1:0] != 0.
  - fetch_addr[31:IDX_W+2] != 0.
  - index >= prog_len.
  - state != READY.
- No error -> fetch_data=mem[index], fetch_err=0.
- Fetch captured in the same cycle as load_start: evaluated against the pre-load state.
- Reset mid-load: returns to EMPTY, prog_len=0; previously written words are unreachable until reloaded.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word is stored with an even-parity bit computed at write.
  - On fetch the parity is rechecked; a mismatch forces fetch_data=NOP_WORD and fetch_err=1.
  - Extra output par_err (1 bit) is high for that fetch_valid cycle and holds under stall.
- Undefined: no parity storage, no par_err port; behaviour otherwise identical.

Test Plan:
- Reset, fetch_req addr 0x0 -> next cycle fetch_valid=1, fetch_data=0x00000000, fetch_err=1; load_done=0.
- load_start, stream 0x012a4022, 0x012a4020, 0x08000006 (last on 3rd) -> load_done=1, prog_len=3; fetch 0x4 -> 0x012a4020, err=0, 1-cycle latency.
- After load: fetch 0x8 then 0xC -> 0x08000006 err=0, then NOP err=1 (index 3 >= prog_len). Fetch 0x2 -> NOP err=1 (misaligned). Fetch 0x400 with DEPTH=256 -> NOP err=1.
- Fetch 0x0, fetch_stall=1 for 3 cycles while fetch_req toggles to 0x4 -> output stays 0x012a4022/valid for all stalled cycles; 0x4 accepted only after stall drops.
- Load DEPTH words without load_last -> READY after word DEPTH-1, prog_len=DEPTH; extra load_valid ignored; fetch (DEPTH-1)*4 returns last word.
- rst_n low mid-load (after 2 words) -> load_ready=0, load_done=0, prog_len=0 immediately; fetch 0x0 returns NOP err=1. With IMEM_PARITY_EN, force bit flip in mem -> par_err=1, data NOP.

Source files
------------

// File: rtl/imem_loadable.sv
// Boot-loadable instruction memory: streaming load port, registered 1-cycle fetch with stall hold.
// Optional IMEM_PARITY_EN adds per-word even parity with a par_err output.
module imem_loadable #(
    parameter int                DEPTH    = 256,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic                     load_last,
    input  logic [DATA_W-1:0]        load_data,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_addr,
    input  logic                     fetch_stall,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_data,
    output logic                     fetch_err
`ifdef IMEM_PARITY_EN
    ,
    output logic                     par_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  wptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;

    function automatic logic even_par(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    // load_start wins over a word presented in the same cycle
    assign accept = (state == LOAD) && load_valid && !load_start;

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            EMPTY: ;
            LOAD: begin
                load_ready = 1'b1;
                if (accept && (load_last || wptr == IDX_W'(DEPTH - 1)))
                    state_nxt = READY;
            end
            READY: load_done = 1'b1;
            default: state_nxt = EMPTY;
        endcase
        if (load_start)
            state_nxt = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wptr     <= '0;
            prog_len <= '0;
        end else begin
            state <= state_nxt;
            if (load_start) begin
                wptr     <= '0;
                prog_len <= '0;
            end else if (accept) begin
                wptr     <= wptr + 1'b1;
                prog_len <= (IDX_W + 1)'(wptr) + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= load_data;
    end

    // ---- stage p0: fetch request decode against the current (pre-load) state ----
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] rd_p0;
    logic              err_p0;
    logic              bad_p0;

    assign idx_p0 = fetch_addr[IDX_W+1:2];
    assign rd_p0  = mem[idx_p0];
    assign err_p0 = (|fetch_addr[1:0]) || (|fetch_addr[31:IDX_W+2]) ||
                    ((IDX_W + 1)'(idx_p0) >= prog_len) || (state != READY);

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_bad_p0;

    always_ff @(posedge clk) begin
        if (accept)
            par_mem[wptr] <= even_par(load_data);
    end

    assign par_bad_p0 = !err_p0 && (even_par(rd_p0) != par_mem[idx_p0]);
    assign bad_p0     = err_p0 || par_bad_p0;
`else
    assign bad_p0 = err_p0;
`endif

    // ---- stage p1: registered fetch result, frozen while stalled ----
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= NOP_WORD;
            err_p1  <= 1'b0;
        end else if (!fetch_stall) begin
            vld_p1 <= fetch_req;
            if (fetch_req) begin
                data_p1 <= bad_p0 ? NOP_WORD : rd_p0;
                err_p1  <= bad_p0;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_p1 <= 1'b0;
        else if (!fetch_stall)
            par_p1 <= fetch_req && par_bad_p0;
    end

    assign par_err = par_p1;
`endif

    assign fetch_valid = vld_p1;
    assign fetch_data  = data_p1;
    assign fetch_err   = err_p1;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed steps plus randomized loads/fetches against a word-level model.
module tb_imem_loadable;

    localparam int          DEPTH  = 256;
    localparam int          IDX_W  = 8;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h00000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start, load_valid, load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready, load_done;
    logic [IDX_W:0]    prog_len;
    logic              fetch_req, fetch_stall;
    logic [31:0]       fetch_addr;
    logic              fetch_valid, fetch_err;
    logic [DATA_W-1:0] fetch_data;
`ifdef IMEM_PARITY_EN
    logic              par_err;
`endif

    imem_loadable #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .prog_len(prog_len),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err)
`ifdef IMEM_PARITY_EN
        , .par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    // reference model: program as a plain word list with a length and a loaded flag
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] src [DEPTH];
    int          ref_len;
    bit          ref_loading, ref_ready;
    bit          exp_valid, exp_err;
    logic [31:0] exp_data;
    int          checks, errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_fetch(input logic [31:0] addr, output logic [31:0] d, output bit e);
        int idx;
        e = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        if (!e) begin
            idx = int'(addr / 4);
            e   = (idx >= ref_len) || !ref_ready;
        end
        d = e ? NOP : ref_mem[int'(addr / 4)];
    endfunction

    // apply current inputs for one clock edge, advancing the model alongside
    task automatic tick();
        logic [31:0] d;
        bit          e;
        if (!fetch_stall) begin
            exp_valid = fetch_req;
            if (fetch_req) begin
                ref_fetch(fetch_addr, d, e);
                exp_data = d;
                exp_err  = e;
            end
        end
        if (load_start) begin
            ref_loading = 1'b1;
            ref_ready   = 1'b0;
            ref_len     = 0;
        end else if (ref_loading && load_valid) begin
            ref_mem[ref_len] = load_data;
            ref_len++;
            if (load_last || ref_len == DEPTH) begin
                ref_loading = 1'b0;
                ref_ready   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag);
        check({tag, " valid"}, 64'(fetch_valid), 64'(exp_valid));
        if (exp_valid) begin
            check({tag, " data"}, 64'(fetch_data), 64'(exp_data));
            check({tag, " err"}, 64'(fetch_err), 64'(exp_err));
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " load_ready"}, 64'(load_ready), 64'(ref_loading));
        check({tag, " load_done"}, 64'(load_done), 64'(ref_ready));
        check({tag, " prog_len"}, 64'(prog_len), 64'(ref_len));
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check_fetch(tag);
    endtask

    task automatic stream(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = src[i];
            load_last  = with_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit with_last);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        stream(n, with_last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          r;
        logic [31:0] a;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
        ref_len = 0; ref_loading = 0; ref_ready = 0;
        exp_valid = 0; exp_data = NOP; exp_err = 0;

        #12;
        check_status("reset");
        check("reset fetch_valid", 64'(fetch_valid), 64'd0);
        check("reset fetch_data", 64'(fetch_data), 64'(NOP));
        check("reset fetch_err", 64'(fetch_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fetch before anything is loaded
        fetch(32'h0, "unloaded");
        check("unloaded err", 64'(fetch_err), 64'd1);
        check_status("unloaded");

        // three-word program
        src[0] = 32'h012a4022; src[1] = 32'h012a4020; src[2] = 32'h08000006;
        load_prog(3, 1'b1);
        check_status("load3");
        check("load3 prog_len", 64'(prog_len), 64'd3);
        fetch(32'h4, "addr4");
        check("addr4 data", 64'(fetch_data), 64'h012a4020);
        tick();
        check_fetch("idle");
        fetch(32'h8, "addr8");
        fetch(32'hC, "addrC");
        check("addrC err", 64'(fetch_err), 64'd1);
        fetch(32'h2, "misaligned");
        check("misaligned err", 64'(fetch_err), 64'd1);
        fetch(32'h400, "range");
        check("range err", 64'(fetch_err), 64'd1);

        // stall holds output; the request behind it is taken only once stall drops
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h4; fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_req = (i != 1);
            tick();
            check_fetch("stall");
            check("stall held data", 64'(fetch_data), 64'h012a4022);
        end
        fetch_stall = 1'b0; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check_fetch("unstall");
        check("unstall data", 64'(fetch_data), 64'h012a4020);

        // reload: fetch alongside load_start sees old program; word alongside start dropped
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) src[i] = $urandom;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_start = 1'b1; load_valid = 1'b1; load_data = 32'hdeadbeef;
        tick();
        load_start = 1'b0; load_valid = 1'b0; fetch_req = 1'b0;
        check_fetch("preload");
        check("preload data", 64'(fetch_data), 64'h012a4022);
        stream(n, 1'b1);
        check_status("reload");

        // random fetch traffic with stalls
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, ref_len + 1) * 4);
            else if (r < 8) a = 32'($urandom_range(0, ref_len) * 4) | 32'($urandom_range(1, 3));
            else            a = $urandom;
            fetch_addr  = a;
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 4) == 0);
            tick();
            check_fetch("rand");
        end
        fetch_req = 1'b0; fetch_stall = 1'b0;
        check_status("rand");

        // fill to capacity without load_last
        for (int i = 0; i < DEPTH; i++) src[i] = $urandom;
        load_prog(DEPTH, 1'b0);
        check_status("full");
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = $urandom;
            tick();
        end
        load_valid = 1'b0;
        check_status("full extra");
        fetch(32'((DEPTH - 1) * 4), "full last");
        check("full last data", 64'(fetch_data), 64'(src[DEPTH-1]));
        fetch(32'h400, "full range");

        // asynchronous reset in the middle of a load
        src[0] = $urandom; src[1] = $urandom;
        load_prog(2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst load_ready", 64'(load_ready), 64'd0);
        check("midrst load_done", 64'(load_done), 64'd0);
        check("midrst prog_len", 64'(prog_len), 64'd0);
        check("midrst fetch_valid", 64'(fetch_valid), 64'd0);
        ref_loading = 0; ref_ready = 0; ref_len = 0;
        exp_valid = 0; exp_data = NOP; exp_err = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fetch(32'h0, "after reset");
        check("after reset err", 64'(fetch_err), 64'd1);

`ifdef IMEM_PARITY_EN
        src[0] = 32'h12345678;
        load_prog(1, 1'b1);
        dut.mem[0] = 32'h12345679;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        check("parity par_err", 64'(par_err), 64'd1);
        check("parity data", 64'(fetch_data), 64'(NOP));
        check("parity err", 64'(fetch_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
